reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
// - 32 x 32-bit general-purpose register file; sink of the write-back select mux (MUX4T1_32 output -> wb_data).
// - Two combinational operand read ports feed the ALU / operand muxes; a third debug read port feeds the display/VGA path.
// - Register 0 is hardwired to zero. Writes commit on the rising clock edge. A write counter supports debug and verification.
// PARAMETERS
// - DATA_W   32  register / data width
// - ADDR_W   5   register address width; depth = 2**ADDR_W
// - BYPASS   0   1: a read of the register being written returns wb_data in the same cycle; 0: it returns the old value
// - CNT_W    16  width of the write-commit counter
// PORTS
// - clk        in   1       system clock, rising edge
// - rst_n      in   1       asynchronous, active-low reset
// - rs_addr    in   ADDR_W  read port A address
// - rt_addr    in   ADDR_W  read port B address
// - rs_data    out  DATA_W  read port A data, combinational
// - rt_data    out  DATA_W  read port B data, combinational
// - we         in   1       write enable (RegWrite from control)
// - wd_addr    in   ADDR_W  write destination register
// - wb_data    in   DATA_W  write data from the write-back 4:1 mux
// - dbg_addr   in   ADDR_W  debug read address
// - dbg_data   out  DATA_W  debug read data, combinational, never bypassed
// - wr_cnt     out  CNT_W   number of committed writes since reset
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous, independent of clk): all registers 1..31 clear to 0; wr_cnt clears to 0.
//   rs_data, rt_data and dbg_data therefore read 0 while reset is held.
// - Commit: on posedge clk with rst_n=1, we=1 and wd_addr!=0, reg[wd_addr] <= wb_data and wr_cnt <= wr_cnt+1.
// - A write to wd_addr=0 is dropped: reg 0 is unchanged, wr_cnt is unchanged. A cycle with we=0 changes no state.
// - wr_cnt wraps modulo 2**CNT_W, with no saturation and no flag.
// - Read: x_data = (x_addr==0) ? 0 : reg[x_addr], with zero latency. Only x_data is combinational; no state changes on a read.
// - Same-cycle read/write of the same nonzero register (we=1, wd_addr==rs_addr or rt_addr):
//   - BYPASS=0: the port returns the pre-edge value and the new value appears after the edge.
//   - BYPASS=1: the port returns wb_data immediately. The bypass never applies to address 0.
// - Both read ports may address the same register, and either may equal wd_addr. Each port resolves independently.
// - Reset asserted mid-cycle, or coincident with a write edge: reset wins and the write is lost.
// - Reset release: the first write can commit on the first posedge after rst_n rises.
// - No X propagation: out-of-range addresses are impossible because depth = 2**ADDR_W.
// STRUCTURE
// - Shared package/header:
//   - constants REG_ZERO=0, RF_DEPTH=2**ADDR_W
//   - default widths DATA_W=32, ADDR_W=5
//   - these are shared with the control unit and the write-back mux select encoding.
// - Storage: one reg array [1:RF_DEPTH-1], plus the wr_cnt register in the same always block with the async reset.
// - Sub-module rf_read_port (addr, array-slot data, bypass hit, wb_data -> data), combinational:
//   - instantiated for port A and port B with the BYPASS parameter passed through
//   - instantiated for the debug port with bypass tied off
// TESTING
// - Reset: pulse rst_n low for 3 ns between edges.
//   -> all ports read 0 immediately, wr_cnt=0, no clock edge required.
// - Basic write: we=1, wd_addr=5, wb_data=32'hDEADBEEF, one edge.
//   -> rs_addr=5 gives 32'hDEADBEEF; dbg_addr=5 gives the same; wr_cnt=1.
// - Zero register: we=1, wd_addr=0, wb_data=32'hFFFFFFFF.
//   -> rs_data(0)=0 and wr_cnt unchanged.
// - Write/read collision: reg7=32'h1; drive we=1, wd_addr=7, wb_data=32'h2 with rs_addr=rt_addr=7.
//   -> BYPASS=0: 32'h1 before the edge, 32'h2 after. BYPASS=1: 32'h2 before the edge. dbg_data=32'h1 before the edge in both cases.
// - Counter wrap: CNT_W=4, 17 writes to reg 3.
//   -> wr_cnt=1; reg3 holds the last value.
// - Reset mid-operation: write 32'hA5A5A5A5 to reg 9, then assert rst_n low at the same edge as a write of 32'h5 to reg 9.
//   -> reg9=0, wr_cnt=0 after release.

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// Shared register-file constants, also used by the control unit and the
// write-back mux select encoding.
package reg_file_wb_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int REG_ZERO  = 0;
  localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

  // Number of register slots for a given address width.
  function automatic int rf_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/reg_file_wb_read_port.sv
// Combinational read port: register 0 reads as zero, and an optional bypass
// forwards the in-flight write-back data on an address hit.
module rf_read_port
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] slot_data_i,
  input  logic              hit_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = slot_data_i;
    if (addr_i == ADDR_W'(REG_ZERO)) begin
      data_o = '0;
    end else if (BYPASS && hit_i) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32 x 32 register file with write-back commit, two operand read ports,
// a never-bypassed debug read port and a wrapping write-commit counter.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wd_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_d;
  logic              wr_commit;

  always_comb begin
    wr_commit = we && (wd_addr != ADDR_W'(REG_ZERO));
    wr_cnt_d  = wr_cnt_q;
    if (wr_commit) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  // Reset is asynchronous and wins over a coincident write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      if (wr_commit) begin
        regs_q[wd_addr] <= wb_data;
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign wr_cnt = wr_cnt_q;

  logic [ADDR_W-1:0] op_addr [2];
  logic [DATA_W-1:0] op_data [2];

  assign op_addr[0] = rs_addr;
  assign op_addr[1] = rt_addr;
  assign rs_data    = op_data[0];
  assign rt_data    = op_data[1];

  // Hit is gated with rst_n so held reset reads zero even when bypassing.
  for (genvar gi = 0; gi < 2; gi++) begin : g_op_port
    logic [DATA_W-1:0] slot_data;
    logic              hit;

    assign slot_data = (op_addr[gi] == ADDR_W'(REG_ZERO)) ? '0 : regs_q[op_addr[gi]];
    assign hit       = rst_n && wr_commit && (wd_addr == op_addr[gi]);

    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_port (
      .addr_i      (op_addr[gi]),
      .slot_data_i (slot_data),
      .hit_i       (hit),
      .wb_data_i   (wb_data),
      .data_o      (op_data[gi])
    );
  end

  logic [DATA_W-1:0] dbg_slot;

  assign dbg_slot = (dbg_addr == ADDR_W'(REG_ZERO)) ? '0 : regs_q[dbg_addr];

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (1'b0)
  ) u_dbg_port (
    .addr_i      (dbg_addr),
    .slot_data_i (dbg_slot),
    .hit_i       (1'b0),
    .wb_data_i   (wb_data),
    .data_o      (dbg_data)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Drives a non-bypassing/16-bit-counter instance and a bypassing/4-bit-counter
// instance in lockstep and compares both against a behavioural array model.
module tb_reg_file_wb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, wd_addr, dbg_addr;
  logic        we;
  logic [31:0] wb_data;
  logic [31:0] rs0, rt0, dbg0, rs1, rt1, dbg1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_rf [32];
  int          ref_cnt;

  reg_file_wb #(.BYPASS(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs0), .rt_data(rt0), .we(we), .wd_addr(wd_addr),
    .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg0), .wr_cnt(cnt0)
  );

  reg_file_wb #(.BYPASS(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs1), .rt_data(rt1), .we(we), .wd_addr(wd_addr),
    .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg1), .wr_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit bypass);
    if (a == 5'd0) return 32'h0;
    if (bypass && rst_n && we && wd_addr == a) return wb_data;
    return ref_rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
    ref_cnt = 0;
  endtask

  // Advance one edge, applying the pending write to the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n && we && wd_addr != 5'd0) begin
      ref_rf[wd_addr] = wb_data;
      ref_cnt++;
    end
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_rs0"},  rs0,  exp_rd(rs_addr, 1'b0));
    chk({tag, "_rt0"},  rt0,  exp_rd(rt_addr, 1'b0));
    chk({tag, "_rs1"},  rs1,  exp_rd(rs_addr, 1'b1));
    chk({tag, "_rt1"},  rt1,  exp_rd(rt_addr, 1'b1));
    chk({tag, "_dbg0"}, dbg0, exp_rd(dbg_addr, 1'b0));
    chk({tag, "_dbg1"}, dbg1, exp_rd(dbg_addr, 1'b0));
    chk({tag, "_cnt0"}, {16'h0, cnt0}, 32'(ref_cnt & 32'hFFFF));
    chk({tag, "_cnt1"}, {28'h0, cnt1}, 32'(ref_cnt & 32'hF));
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wd_addr = '0; wb_data = '0;
    rs_addr = '0; rt_addr = '0; dbg_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Populate some state, then a 3 ns reset pulse between edges.
    we = 1'b1; wd_addr = 5'd4; wb_data = 32'h1234_5678; rs_addr = 5'd4; rt_addr = 5'd4; dbg_addr = 5'd4;
    tick();
    we = 1'b0;
    #1 chk_all("prefill");
    rst_n = 1'b0;
    model_reset();
    #1 chk_all("rst_pulse");
    #2 rst_n = 1'b1;
    #1 chk_all("rst_release");
    $display("txn reset_pulse checks=%0d failures=%0d", checks, failures);

    // Basic write.
    we = 1'b1; wd_addr = 5'd5; wb_data = 32'hDEAD_BEEF; rs_addr = 5'd5; rt_addr = 5'd0; dbg_addr = 5'd5;
    #1 chk_all("basic_pre");
    tick();
    we = 1'b0;
    #1 chk_all("basic_post");
    chk("basic_rs_lit", rs0, 32'hDEAD_BEEF);
    chk("basic_cnt_lit", {16'h0, cnt0}, 32'd1);
    $display("txn basic_write checks=%0d failures=%0d", checks, failures);

    // Write to register 0 is dropped.
    we = 1'b1; wd_addr = 5'd0; wb_data = 32'hFFFF_FFFF; rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
    #1 chk_all("zero_pre");
    tick();
    we = 1'b0;
    #1 chk_all("zero_post");
    chk("zero_cnt_lit", {16'h0, cnt0}, 32'd1);
    $display("txn zero_write checks=%0d failures=%0d", checks, failures);

    // Collision on register 7.
    we = 1'b1; wd_addr = 5'd7; wb_data = 32'h1;
    tick();
    wb_data = 32'h2; rs_addr = 5'd7; rt_addr = 5'd7; dbg_addr = 5'd7;
    #1 chk_all("coll_pre");
    chk("coll_rs0_old", rs0, 32'h1);
    chk("coll_rs1_new", rs1, 32'h2);
    chk("coll_dbg1_old", dbg1, 32'h1);
    tick();
    we = 1'b0;
    #1 chk_all("coll_post");
    chk("coll_rt0_new", rt0, 32'h2);
    $display("txn collision checks=%0d failures=%0d", checks, failures);

    // Randomized traffic; small address range keeps collisions frequent.
    for (int n = 0; n < 300; n++) begin
      we       = ($urandom_range(0, 3) != 0);
      wd_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wb_data  = $urandom;
      rs_addr  = ($urandom_range(0, 2) == 0) ? wd_addr : 5'($urandom_range(0, 7));
      rt_addr  = ($urandom_range(0, 2) == 0) ? wd_addr : 5'($urandom);
      dbg_addr = ($urandom_range(0, 2) == 0) ? wd_addr : 5'($urandom);
      #1 chk_all("rand");
      tick();
    end
    we = 1'b0;
    #1 chk_all("rand_end");
    $display("txn random checks=%0d failures=%0d", checks, failures);

    // Counter wrap: 17 writes to register 3 from a fresh reset.
    rst_n = 1'b0; model_reset();
    #2 rst_n = 1'b1;
    for (int n = 0; n < 17; n++) begin
      we = 1'b1; wd_addr = 5'd3; wb_data = 32'hC000_0000 + n;
      tick();
    end
    we = 1'b0; rs_addr = 5'd3; rt_addr = 5'd3; dbg_addr = 5'd3;
    #1 chk_all("wrap");
    chk("wrap_cnt1_lit", {28'h0, cnt1}, 32'd1);
    chk("wrap_cnt0_lit", {16'h0, cnt0}, 32'd17);
    chk("wrap_reg3_lit", dbg0, 32'hC000_0010);
    $display("txn counter_wrap checks=%0d failures=%0d", checks, failures);

    // Reset coincident with a write edge: reset wins.
    we = 1'b1; wd_addr = 5'd9; wb_data = 32'hA5A5_A5A5;
    tick();
    rs_addr = 5'd9; dbg_addr = 5'd9; wb_data = 32'h5;
    #1 chk("mid_pre", dbg0, 32'hA5A5_A5A5);
    @(negedge clk);
    #5 rst_n = 1'b0;
    model_reset();
    #2 we = 1'b0;
    rst_n = 1'b1;
    #1 chk_all("mid_post");
    chk("mid_reg9_lit", rs0, 32'h0);
    chk("mid_cnt_lit", {16'h0, cnt0}, 32'h0);

    // First write after release commits on the first edge.
    we = 1'b1; wd_addr = 5'd9; wb_data = 32'h0BAD_F00D;
    tick();
    we = 1'b0;
    #1 chk_all("post_rel");
    chk("post_rel_lit", rs0, 32'h0BAD_F00D);
    $display("txn reset_mid_op checks=%0d failures=%0d", checks, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
